// File: rtl/ifetch_unit_pkg.sv
// ============================================================================
// Module   : pkg_parameters
// Purpose  : Shared widths, fetch defaults and the fetch packet type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pkg_parameters;
  localparam int IMEM_ADDR_WIDTH  = 32;
  localparam int IMEM_DATA_WIDTH  = 32;
  localparam int FETCH_FIFO_DEPTH = 2;
  localparam logic [IMEM_ADDR_WIDTH-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [IMEM_ADDR_WIDTH-1:0] pc;
    logic [IMEM_DATA_WIDTH-1:0] instr;
  } fetch_pkt_t;
endpackage

`default_nettype wire

// File: rtl/ifetch_unit_fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO of fetch packets with push/pop/flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import pkg_parameters::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_pkt_t    push_pkt,
  input  logic          pop,
  output fetch_pkt_t    head_pkt,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  fetch_pkt_t    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == C_FULL);
  assign count     = r_count;
  assign head_pkt  = r_mem[r_rptr];
  assign w_do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= (r_wptr == C_LAST) ? '0 : r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && w_do_push) r_mem[r_wptr] <= push_pkt;
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Instruction fetch initiator: PC, single in-flight imem read,
//            fetch buffer and valid/ready hand-off to decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit
  import pkg_parameters::*;
#(
  parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                         FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic                       imem_ena,
  input  logic [IMEM_DATA_WIDTH-1:0] imem_dout,
  input  logic                       redirect_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IMEM_ADDR_WIDTH-1:0] out_pc,
  output logic [IMEM_DATA_WIDTH-1:0] out_instr
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(FIFO_DEPTH);

  logic [IMEM_ADDR_WIDTH-1:0] r_pc;
  logic [IMEM_ADDR_WIDTH-1:0] r_inflight_pc;
  logic                       r_inflight;

  logic [IMEM_ADDR_WIDTH-1:0] w_redirect_target;
  logic [CW-1:0]              w_fifo_count;
  logic                       w_fifo_empty;
  logic                       w_fifo_full;
  logic                       w_pop;
  logic                       w_push;
  logic [CW:0]                w_outstanding;
  fetch_pkt_t                 w_head;
  fetch_pkt_t                 w_push_pkt;

  assign w_redirect_target = redirect_pc & ~IMEM_ADDR_WIDTH'(3);

  assign out_valid = !rst && !w_fifo_empty;
  assign out_pc    = out_valid ? w_head.pc    : '0;
  assign out_instr = out_valid ? w_head.instr : '0;
  assign w_pop     = out_valid && out_ready;

  // Buffered entries plus the read in flight, less what leaves this cycle,
  // must leave room for the word this cycle's issue will return.
  assign w_outstanding = {1'b0, w_fifo_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
  assign imem_ena  = !rst && !redirect_valid && (w_outstanding < C_DEPTH)
                     && !(w_fifo_full && !w_pop && r_inflight);
  assign imem_addr = rst ? RESET_PC : r_pc;

  assign w_push           = r_inflight;
  assign w_push_pkt.pc    = r_inflight_pc;
  assign w_push_pkt.instr = imem_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= w_redirect_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_ena;
      if (imem_ena) begin
        r_pc          <= r_pc + IMEM_ADDR_WIDTH'(4);
        r_inflight_pc <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (w_push),
    .push_pkt (w_push_pkt),
    .pop      (w_pop),
    .head_pkt (w_head),
    .count    (w_fifo_count),
    .empty    (w_fifo_empty),
    .full     (w_fifo_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module   : tb_ifetch_unit
// Purpose  : Self-checking bench: directed vector table, randomized stream
//            against a queue-based reference model, and PC wrap sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;
  localparam int D0 = 3;

  logic        clk = 1'b0;
  logic        rst0, redir0, rdy0, ena0, vld0;
  logic [31:0] rpc0, addr0, dout0, opc0, oins0;
  logic        rst1, redir1, rdy1, ena1, vld1;
  logic [31:0] rpc1, addr1, dout1, opc1, oins1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.FIFO_DEPTH(D0)) u_dut0 (
    .clk(clk), .rst(rst0), .imem_addr(addr0), .imem_ena(ena0), .imem_dout(dout0),
    .redirect_valid(redir0), .redirect_pc(rpc0), .out_valid(vld0),
    .out_ready(rdy0), .out_pc(opc0), .out_instr(oins0)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut1 (
    .clk(clk), .rst(rst1), .imem_addr(addr1), .imem_ena(ena1), .imem_dout(dout1),
    .redirect_valid(redir1), .redirect_pc(rpc1), .out_valid(vld1),
    .out_ready(rdy1), .out_pc(opc1), .out_instr(oins1)
  );

  // imem models: word at byte address A is 32'hA0000000 | A, 1-cycle latency
  always @(posedge clk) begin
    dout0 <= ena0 ? (32'hA000_0000 | addr0) : 32'h0;
    dout1 <= ena1 ? (32'hA000_0000 | addr1) : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        ena;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rp, logic rd,
                              logic e, logic [31:0] a, logic v, logic [31:0] p);
    vec_t t;
    t.rst = r; t.redir = rv; t.rpc = rp; t.rdy = rd;
    t.ena = e; t.addr = a; t.vld = v; t.pc = p;
    return t;
  endfunction

  vec_t        tbl [35];
  logic [31:0] qpc [$];
  int          qcyc [$];
  logic [31:0] nxt;
  int          now;
  int          npops;
  logic        exp_v, pop, credit;

  initial begin
    rst0 = 1'b1; redir0 = 1'b0; rpc0 = '0; rdy0 = 1'b1;
    rst1 = 1'b1; redir1 = 1'b0; rpc1 = '0; rdy1 = 1'b1;

    // ---------------- directed vector table (FIFO depth 3) ----------------
    //             rst rv rpc       rdy ena addr      vld pc
    tbl[0]  = mk(1, 0, 32'h0,   1,  0, 32'h0,   0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,   1,  1, 32'h0,   0, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,   1,  1, 32'h4,   0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,   1,  1, 32'h8,   1, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,   1,  1, 32'hC,   1, 32'h4);
    tbl[5]  = mk(0, 0, 32'h0,   1,  1, 32'h10,  1, 32'h8);
    tbl[6]  = mk(1, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0);
    tbl[7]  = mk(0, 0, 32'h0,   0,  1, 32'h0,   0, 32'h0);
    tbl[8]  = mk(0, 0, 32'h0,   0,  1, 32'h4,   0, 32'h0);
    tbl[9]  = mk(0, 0, 32'h0,   0,  1, 32'h8,   1, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,   0,  0, 32'hC,   1, 32'h0);
    tbl[11] = mk(0, 0, 32'h0,   0,  0, 32'hC,   1, 32'h0);
    tbl[12] = mk(0, 0, 32'h0,   0,  0, 32'hC,   1, 32'h0);
    tbl[13] = mk(0, 0, 32'h0,   0,  0, 32'hC,   1, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,   1,  1, 32'hC,   1, 32'h0);
    tbl[15] = mk(0, 0, 32'h0,   1,  1, 32'h10,  1, 32'h4);
    tbl[16] = mk(0, 0, 32'h0,   1,  1, 32'h14,  1, 32'h8);
    tbl[17] = mk(0, 1, 32'h40,  1,  0, 32'h18,  1, 32'hC);
    tbl[18] = mk(0, 0, 32'h0,   1,  1, 32'h40,  0, 32'h0);
    tbl[19] = mk(0, 0, 32'h0,   1,  1, 32'h44,  0, 32'h0);
    tbl[20] = mk(0, 0, 32'h0,   1,  1, 32'h48,  1, 32'h40);
    tbl[21] = mk(0, 0, 32'h0,   1,  1, 32'h4C,  1, 32'h44);
    tbl[22] = mk(0, 1, 32'h43,  1,  0, 32'h50,  1, 32'h48);
    tbl[23] = mk(0, 0, 32'h0,   1,  1, 32'h40,  0, 32'h0);
    tbl[24] = mk(0, 0, 32'h0,   1,  1, 32'h44,  0, 32'h0);
    tbl[25] = mk(0, 0, 32'h0,   1,  1, 32'h48,  1, 32'h40);
    tbl[26] = mk(0, 1, 32'h80,  1,  0, 32'h4C,  1, 32'h44);
    tbl[27] = mk(0, 1, 32'h100, 1,  0, 32'h80,  0, 32'h0);
    tbl[28] = mk(0, 0, 32'h0,   1,  1, 32'h100, 0, 32'h0);
    tbl[29] = mk(0, 0, 32'h0,   1,  1, 32'h104, 0, 32'h0);
    tbl[30] = mk(0, 0, 32'h0,   1,  1, 32'h108, 1, 32'h100);
    tbl[31] = mk(1, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0);
    tbl[32] = mk(0, 0, 32'h0,   1,  1, 32'h0,   0, 32'h0);
    tbl[33] = mk(0, 0, 32'h0,   0,  1, 32'h4,   0, 32'h0);
    tbl[34] = mk(0, 0, 32'h0,   1,  1, 32'h8,   1, 32'h0);

    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      rst0 = tbl[i].rst; redir0 = tbl[i].redir; rpc0 = tbl[i].rpc; rdy0 = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d ena", i), {31'b0, ena0}, {31'b0, tbl[i].ena});
      chk($sformatf("vec%0d addr", i), addr0, tbl[i].addr);
      chk($sformatf("vec%0d valid", i), {31'b0, vld0}, {31'b0, tbl[i].vld});
      if (tbl[i].vld || tbl[i].rst) begin
        chk($sformatf("vec%0d pc", i), opc0, tbl[i].pc);
        chk($sformatf("vec%0d instr", i), oins0,
            tbl[i].vld ? (32'hA000_0000 | tbl[i].pc) : 32'h0);
      end
    end

    // ---------------- randomized stream vs queue reference model ----------
    @(posedge clk); #1;
    rst0 = 1'b1; redir0 = 1'b0; rdy0 = 1'b0;
    @(negedge clk);
    qpc.delete(); qcyc.delete(); nxt = 32'h0; now = 0; npops = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      rst0   = ($urandom_range(99) == 0);
      redir0 = !rst0 && ($urandom_range(99) < 5);
      rpc0   = $urandom;
      rdy0   = ($urandom_range(99) < 70);
      @(negedge clk);
      now++;
      if (rst0) begin
        chk("rnd rst ena", {31'b0, ena0}, 32'h0);
        chk("rnd rst valid", {31'b0, vld0}, 32'h0);
        chk("rnd rst addr", addr0, 32'h0);
        qpc.delete(); qcyc.delete(); nxt = 32'h0;
      end else begin
        // a word becomes visible two cycles after its issue
        exp_v = (qpc.size() > 0) && (qcyc[0] <= now - 2);
        chk("rnd valid", {31'b0, vld0}, {31'b0, exp_v});
        if (exp_v) begin
          chk("rnd pc", opc0, qpc[0]);
          chk("rnd instr", oins0, 32'hA000_0000 | qpc[0]);
        end
        if (redir0) begin
          chk("rnd redir ena", {31'b0, ena0}, 32'h0);
          qpc.delete(); qcyc.delete(); nxt = rpc0 & ~32'h3;
        end else begin
          pop    = exp_v && rdy0;
          credit = (qpc.size() - int'(pop)) < D0;
          chk("rnd ena", {31'b0, ena0}, {31'b0, credit});
          if (pop) begin
            void'(qpc.pop_front()); void'(qcyc.pop_front());
            npops++;
          end
          if (credit) begin
            chk("rnd addr", addr0, nxt);
            qpc.push_back(nxt); qcyc.push_back(now);
            nxt = nxt + 32'h4;
          end
        end
      end
    end
    chk("rnd progress", {31'b0, (npops > 200)}, 32'h1);

    // ---------------- PC wrap near top of address space -------------------
    @(posedge clk); #1; rst1 = 1'b1; rdy1 = 1'b1;
    @(negedge clk);
    chk("wrap rst addr", addr1, 32'hFFFF_FFF8);
    chk("wrap rst ena", {31'b0, ena1}, 32'h0);
    @(posedge clk); #1; rst1 = 1'b0;
    @(negedge clk);
    chk("wrap addr0", addr1, 32'hFFFF_FFF8);
    @(posedge clk); @(negedge clk);
    chk("wrap addr1", addr1, 32'hFFFF_FFFC);
    @(posedge clk); @(negedge clk);
    chk("wrap addr2", addr1, 32'h0);
    chk("wrap pkt0 valid", {31'b0, vld1}, 32'h1);
    chk("wrap pkt0 pc", opc1, 32'hFFFF_FFF8);
    chk("wrap pkt0 instr", oins1, 32'hFFFF_FFF8);
    @(posedge clk); @(negedge clk);
    chk("wrap pkt1 pc", opc1, 32'hFFFF_FFFC);
    @(posedge clk); @(negedge clk);
    chk("wrap pkt2 pc", opc1, 32'h0);
    chk("wrap pkt2 instr", oins1, 32'hA000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
